// File: rtl/device_uart_rx_pkg.sv
// Shared UART constants, receiver FSM encoding and received-frame payload.
package device_uart_rx_pkg;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 5200;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_error;
    logic                 framing_error;
  } rx_result_t;
endpackage

// File: rtl/uart_rx_baud_timer.sv
// Bit-period counter: mid-bit tick for start validation, end-of-bit tick for sampling.
module uart_rx_baud_timer
  import device_uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned SAMPLE_POINT = CLKS_PER_BIT / 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic mid_tick_c,
  output logic end_tick_c
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] count;

  // Counter rests at zero whenever the receiver is not timing a bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || !enable || end_tick_c) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign mid_tick_c = enable && (count == CW'(SAMPLE_POINT - 1));
  assign end_tick_c = enable && (count == CW'(CLKS_PER_BIT - 1));
endmodule

// File: rtl/device_uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, registered outputs.
module device_uart_rx
  import device_uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned SAMPLE_POINT = CLKS_PER_BIT / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serialInputRx,
  output logic [DATA_BITS-1:0] dataReceived,
  output logic                 rxValid,
  output logic                 parityError,
  output logic                 framingError,
  output logic                 busyRx
);
  localparam int unsigned IW = $clog2(DATA_BITS);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic                 parity_bit_q, parity_bit_d;
  rx_result_t           result_q, result_d;
  logic                 valid_q, valid_d;
  logic                 busy_q;
  logic                 timer_clear_c, timer_en_c, mid_tick_c, end_tick_c;

  assign rx_s       = sync_q[1];
  assign timer_en_c = (state_q != ST_IDLE) && (state_q != ST_WAIT_IDLE);

  uart_rx_baud_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_POINT(SAMPLE_POINT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear_c),
    .enable    (timer_en_c),
    .mid_tick_c(mid_tick_c),
    .end_tick_c(end_tick_c)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= 2'b11;
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      parity_bit_q <= 1'b0;
      result_q     <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], serialInputRx};
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      parity_bit_q <= parity_bit_d;
      result_q     <= result_d;
      valid_q      <= valid_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    parity_bit_d  = parity_bit_q;
    result_d      = result_q;
    valid_d       = 1'b0;
    timer_clear_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          timer_clear_c = 1'b1;
          state_d       = ST_START;
        end
      end
      ST_START: begin
        if (mid_tick_c) begin
          if (!rx_s) begin
            timer_clear_c = 1'b1;
            bit_idx_d     = '0;
            state_d       = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (end_tick_c) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + IW'(1);
          if (bit_idx_q == IW'(DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (end_tick_c) begin
          parity_bit_d = rx_s;
          state_d      = ST_STOP;
        end
      end
      ST_STOP: begin
        if (end_tick_c) begin
          result_d.data          = shift_q;
          result_d.parity_error  = ^{shift_q, parity_bit_q};
          result_d.framing_error = ~rx_s;
          valid_d                = 1'b1;
          // A low stop bit may be a break; wait for idle before hunting for a start bit.
          state_d                = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dataReceived = result_q.data;
  assign parityError  = result_q.parity_error;
  assign framingError = result_q.framing_error;
  assign rxValid      = valid_q;
  assign busyRx       = busy_q;
endmodule

// File: doc/device_uart_rx.md
DEVICE_UART_RX -- requirements
Module: device_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5200, clock cycles per bit period; it SHALL match the transmitter bit period.
REQ-002 Parameter SAMPLE_POINT, default CLKS_PER_BIT/2, cycle within a bit at which the line SHALL be sampled.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 serialInputRx  input  1  asynchronous serial line; idle level 1.
REQ-006 dataReceived  output  8  last received byte; SHALL be held until the next frame completes.
REQ-007 rxValid  output  1  one-cycle pulse marking a completed frame.
REQ-008 parityError  output  1  even-parity mismatch of the last frame; valid with rxValid, held until the next frame completes.
REQ-009 framingError  output  1  stop bit sampled 0 in the last frame; valid with rxValid, held until the next frame completes.
REQ-010 busyRx  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 The frame format SHALL be: start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
REQ-012 serialInputRx SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value (rx_s).
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-014 IDLE: when rx_s is 0, the FSM SHALL clear the bit-period counter and go to START.
REQ-015 START: at count SAMPLE_POINT-1, rx_s=0 SHALL go to DATA with the counter restarted; rx_s=1 (glitch) SHALL return to IDLE with no outputs changed.
REQ-016 DATA: at each count CLKS_PER_BIT-1, the FSM SHALL shift rx_s into the MSB of the shift register (right shift) and increment the bit index; after bit index 7 it SHALL go to PARITY.
REQ-017 PARITY: at count CLKS_PER_BIT-1, it SHALL capture the parity bit and go to STOP.
REQ-018 STOP: at count CLKS_PER_BIT-1, it SHALL load dataReceived from the shift register and compute parityError = XOR(data, parity bit).
REQ-019 In the same STOP sample cycle, it SHALL set framingError = ~rx_s and assert rxValid for the next cycle only.
REQ-020 After STOP, rx_s=1 SHALL go to IDLE; rx_s=0 SHALL go to WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL remain until rx_s=1, then go to IDLE; this prevents a break condition from starting a false frame.
REQ-022 Counter width SHALL be $clog2(CLKS_PER_BIT); the counter SHALL wrap to 0 at CLKS_PER_BIT-1 and SHALL be held at 0 in IDLE and WAIT_IDLE.
REQ-023 Latency: rxValid SHALL rise 2 + SAMPLE_POINT + 10*CLKS_PER_BIT cycles (plus or minus 1) after the start-bit falling edge on serialInputRx.
REQ-024 Back-to-back frames: a start bit immediately following a valid stop bit SHALL be received with no lost frame.
REQ-025 All outputs SHALL be registered; no combinational path from serialInputRx to any output.

Reset
REQ-026 While rst=0: FSM in IDLE; counter, bit index and shift register 0; synchronizer flops 1.
REQ-027 While rst=0: dataReceived=8'h00; rxValid, parityError, framingError and busyRx all 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame without a rxValid pulse; after release, reception SHALL resume on the next falling edge.

Structure
REQ-029 FSM state encodings (3-bit), frame constants (DATA_BITS=8) and the default CLKS_PER_BIT SHALL live in the shared UART parameter include used by the TX device.
REQ-030 The bit-period timer SHALL be one sub-module, uart_rx_baud_timer (clear, enable, mid-bit tick and end-of-bit tick outputs).
REQ-031 Synchronizer, FSM, shift register and output registers SHALL reside in device_uart_rx.

Verification (CLKS_PER_BIT=16, SAMPLE_POINT=8)
REQ-032 Frame 0xA5, parity 0, stop 1 -> dataReceived=8'hA5, one rxValid pulse, parityError=0, framingError=0.
REQ-033 Frame 0x01 with parity bit 0 -> dataReceived=8'h01, parityError=1, framingError=0.
REQ-034 Frame 0x3C with stop bit 0 and the line held low 40 cycles -> framingError=1; no second rxValid; busyRx stays high until the line returns to 1.
REQ-035 Line low for 4 cycles, then high -> no rxValid; busyRx returns to 0 within SAMPLE_POINT+3 cycles; dataReceived unchanged.
REQ-036 Frames 0x55 then 0xFF back-to-back -> two rxValid pulses 176 cycles apart, with the correct bytes and no errors.
REQ-037 rst pulsed during DATA bit 4 -> all outputs 0, no rxValid; a following 0x0F frame is received correctly.
